// File: rtl/bank_timing_ctrl_pkg.sv
// Shared types for the per-bank DRAM timing controller:
// state codes, command bit indices and bank-op legality.
package bank_timing_ctrl_pkg;

  localparam int CMDW = 19;

  localparam int C_WRA  = 0;
  localparam int C_WR   = 1;
  localparam int C_SRF  = 2;
  localparam int C_REF  = 3;
  localparam int C_RDA  = 4;
  localparam int C_RD   = 5;
  localparam int C_PRA  = 6;
  localparam int C_PR   = 7;
  localparam int C_PDX  = 8;
  localparam int C_PD   = 9;
  localparam int C_MRW  = 10;
  localparam int C_MRR  = 11;
  localparam int C_DPDX = 12;
  localparam int C_DPD  = 13;
  localparam int C_CKEL = 14;
  localparam int C_CKEH = 15;
  localparam int C_CFG  = 16;
  localparam int C_BST  = 17;
  localparam int C_ACT  = 18;

  typedef enum logic [4:0] {
    ST_IDLE        = 5'h00,
    ST_ACTIVATING  = 5'h01,
    ST_ACTIVE      = 5'h03,
    ST_PRECHARGING = 5'h0a,
    ST_READING     = 5'h0b,
    ST_READING_AP  = 5'h0c,
    ST_REFRESHING  = 5'h0d,
    ST_WRITING     = 5'h12,
    ST_WRITING_AP  = 5'h13
  } bank_st_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ACT,
    OP_RD,
    OP_WR,
    OP_RDA,
    OP_WRA,
    OP_PR,
    OP_REF
  } bank_op_e;

  // Column and precharge commands need an open row with no burst in flight.
  function automatic logic bank_ok(bank_op_e op, bank_st_e st,
                                   logic expired);
    logic ready;
    logic ok;
    ready = (st == ST_ACTIVE) ||
            (((st == ST_READING) || (st == ST_WRITING)) && expired);
    ok = 1'b0;
    unique case (op)
      OP_ACT:  ok = (st == ST_IDLE);
      OP_RD,
      OP_WR,
      OP_RDA,
      OP_WRA:  ok = ready;
      OP_PR:   ok = ready || (st == ST_IDLE);
      OP_REF:  ok = (st == ST_IDLE);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bank_timing_if.sv
// Command/status bundle between a command source and the
// bank timing controller.
interface bank_timing_if #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2
);
  import bank_timing_ctrl_pkg::*;

  localparam int BGW = (BGWIDTH > 0) ? BGWIDTH : 1;
  localparam int NBG = 1 << BGWIDTH;
  localparam int NBA = 1 << BAWIDTH;

  logic [BGW-1:0]               bg;
  logic [BAWIDTH-1:0]           ba;
  logic [CMDW-1:0]              commands;
  logic [NBG-1:0][NBA-1:0][4:0] BankFSM;
  logic                         cmd_illegal;
  logic                         all_idle;

  modport master (
    output bg, ba, commands,
    input  BankFSM, cmd_illegal, all_idle
  );

  modport slave (
    input  bg, ba, commands,
    output BankFSM, cmd_illegal, all_idle
  );

endinterface

// File: rtl/bank_timing_ctrl_bank_fsm.sv
// One DRAM bank: state register plus a down-counter that
// times every state and gates the autonomous transitions.
module bank_fsm
  import bank_timing_ctrl_pkg::*;
#(
  parameter int BL    = 8,
  parameter int T_RCD = 17,
  parameter int T_WR  = 14,
  parameter int T_RP  = 17,
  parameter int T_RFC = 34,
  parameter int CNTW  = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     go,
  input  bank_op_e op,
  output bank_st_e st,
  output logic     expired
);

  bank_st_e        st_q, st_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == '0);
  assign st      = st_q;

  // Counter holds N-1 so a state loaded with N stays visible N cycles.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (go) begin
      unique case (op)
        OP_ACT: begin
          st_d  = ST_ACTIVATING;
          cnt_d = CNTW'(T_RCD - 1);
        end
        OP_RD: begin
          st_d  = ST_READING;
          cnt_d = CNTW'(BL - 1);
        end
        OP_WR: begin
          st_d  = ST_WRITING;
          cnt_d = CNTW'(T_WR - 1);
        end
        OP_RDA: begin
          st_d  = ST_READING_AP;
          cnt_d = CNTW'(BL);
        end
        OP_WRA: begin
          st_d  = ST_WRITING_AP;
          cnt_d = CNTW'(T_WR);
        end
        OP_PR: begin
          if (st_q != ST_IDLE) begin
            st_d  = ST_PRECHARGING;
            cnt_d = CNTW'(T_RP - 1);
          end
        end
        OP_REF: begin
          st_d  = ST_REFRESHING;
          cnt_d = CNTW'(T_RFC - 1);
        end
        default: ;
      endcase
    end else if (!expired) begin
      cnt_d = cnt_q - CNTW'(1);
    end else begin
      unique case (st_q)
        ST_ACTIVATING: st_d = ST_ACTIVE;
        ST_READING_AP,
        ST_WRITING_AP: begin
          st_d  = ST_PRECHARGING;
          cnt_d = CNTW'(T_RP - 1);
        end
        ST_PRECHARGING,
        ST_REFRESHING: st_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bank_timing_ctrl.sv
// Registers the command, decodes the target bank, applies the
// global PRA/REF checks and fans the accepted op to the banks.
module bank_timing_ctrl
  import bank_timing_ctrl_pkg::*;
#(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int BL      = 8,
  parameter int T_RCD   = 17,
  parameter int T_WR    = 14,
  parameter int T_RP    = 17,
  parameter int T_RFC   = 34,
  parameter int CNTW    = 8
) (
  input logic          clk,
  input logic          reset,
  bank_timing_if.slave bus
);

  localparam int BGW = (BGWIDTH > 0) ? BGWIDTH : 1;
  localparam int NBG = 1 << BGWIDTH;
  localparam int NBA = 1 << BAWIDTH;
  localparam int NB  = NBG * NBA;

  logic [CMDW-1:0]    cmd_q, cmd_d;
  logic [BGW-1:0]     bg_q, bg_d;
  logic [BAWIDTH-1:0] ba_q, ba_d;
  logic               illegal_q, illegal_d;

  bank_op_e           op;
  logic               global_cmd;
  logic               onehot;
  logic               accept;
  logic [NB-1:0]      sel, ok, pr_ok, idle, go, expd;
  bank_st_e           st [NB];

  logic [NBG-1:0][NBA-1:0][4:0] fsm_v;

  for (genvar g = 0; g < NBG; g++) begin : g_bg
    for (genvar b = 0; b < NBA; b++) begin : g_ba
      localparam int I = g * NBA + b;

      assign sel[I]   = ((BGWIDTH == 0) || (bg_q == BGW'(g))) &&
                        (ba_q == BAWIDTH'(b));
      assign ok[I]    = bank_ok(op, st[I], expd[I]);
      assign pr_ok[I] = bank_ok(OP_PR, st[I], expd[I]);
      assign idle[I]  = (st[I] == ST_IDLE);
      assign fsm_v[g][b] = st[I];

      bank_fsm #(
        .BL    (BL),
        .T_RCD (T_RCD),
        .T_WR  (T_WR),
        .T_RP  (T_RP),
        .T_RFC (T_RFC),
        .CNTW  (CNTW)
      ) u_bank (
        .clk     (clk),
        .rst     (reset),
        .go      (go[I]),
        .op      (op),
        .st      (st[I]),
        .expired (expd[I])
      );
    end
  end

  always_comb begin
    cmd_d      = bus.commands;
    bg_d       = bus.bg;
    ba_d       = bus.ba;
    onehot     = (cmd_q != '0) &&
                 ((cmd_q & (cmd_q - CMDW'(1))) == '0);
    op         = OP_NONE;
    global_cmd = 1'b0;
    if (onehot) begin
      unique case (1'b1)
        cmd_q[C_ACT]: op = OP_ACT;
        cmd_q[C_RD]:  op = OP_RD;
        cmd_q[C_WR]:  op = OP_WR;
        cmd_q[C_RDA]: op = OP_RDA;
        cmd_q[C_WRA]: op = OP_WRA;
        cmd_q[C_PR]:  op = OP_PR;
        cmd_q[C_PRA]: begin
          op         = OP_PR;
          global_cmd = 1'b1;
        end
        cmd_q[C_REF]: begin
          op         = OP_REF;
          global_cmd = 1'b1;
        end
        default: op = OP_NONE;
      endcase
    end
    // PRA is all-or-nothing; REF needs every bank idle.
    if (cmd_q[C_REF])
      accept = &idle;
    else if (cmd_q[C_PRA])
      accept = &pr_ok;
    else
      accept = |(sel & ok);
    go = '0;
    if (onehot && (op != OP_NONE) && accept)
      go = global_cmd ? '1 : sel;
    illegal_d = (cmd_q != '0) &&
                (!onehot || ((op != OP_NONE) && !accept));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q     <= '0;
      bg_q      <= '0;
      ba_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      bg_q      <= bg_d;
      ba_q      <= ba_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.BankFSM     = fsm_v;
  assign bus.cmd_illegal = illegal_q;
  assign bus.all_idle    = &idle;

endmodule

// File: doc/bank_timing_ctrl.md
BANK_TIMING_CTRL -- requirements
Module: bank_timing_ctrl

Interface
REQ-001 SHALL have parameter BGWIDTH, default 2, bank-group address width; 0 means no bank groups (DDR3).
REQ-002 SHALL have parameter BAWIDTH, default 2, bank address width.
REQ-003 SHALL have parameter BL, default 8, burst length in clocks.
REQ-004 SHALL have parameters T_RCD=17, T_WR=14, T_RP=17, T_RFC=34, all in clocks, each >=2.
REQ-005 SHALL have parameter CNTW, default 8, per-bank counter width, sized to hold max(T_RFC, T_WR+1, BL+1).
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high; one clock, asynchronous active-high reset.
REQ-008 bg  input  BGWIDTH  target bank group; ignored when BGWIDTH=0.
REQ-009 ba  input  BAWIDTH  target bank.
REQ-010 commands  input  19  one-hot decoded command vector, MSB..LSB {ACT,BST,CFG,CKEH,CKEL,DPD,DPDX,MRR,MRW,PD,PDX,PR,PRA,RD,RDA,REF,SRF,WR,WRA}.
REQ-011 BankFSM  output  [2^BGWIDTH][2^BAWIDTH] x 5  per-bank state code, registered.
REQ-012 cmd_illegal  output  1  one-cycle pulse, the clock after a rejected command.
REQ-013 all_idle  output  1  high while every bank is Idle.

Function
REQ-014 State codes SHALL be: Idle 0x00, Activating 0x01, Active 0x03, Precharging 0x0a, Reading 0x0b, ReadingAP 0x0c, Refreshing 0x0d, Writing 0x12, WritingAP 0x13.
REQ-015 Each bank SHALL own one CNTW-bit down-counter, loaded on state entry; "expired" means the count is 0.
REQ-016 Commands sampled at edge t SHALL change BankFSM at edge t+1; only the addressed bank is affected, except for PRA and REF.
REQ-017 ACT in Idle SHALL go to Activating for T_RCD cycles, then to Active.
REQ-018 RD / WR SHALL be accepted in Active, in expired Reading, or in expired Writing; they go to Reading (counter BL) or Writing (counter T_WR). The state holds after expiry until the next accepted command.
REQ-019 RDA SHALL go to ReadingAP for BL+1 cycles, then Precharging; WRA SHALL go to WritingAP for T_WR+1 cycles, then Precharging. Both are subject to the same preconditions as RD/WR.
REQ-020 PR SHALL be accepted in Active, expired Reading, or expired Writing, and goes to Precharging for T_RP cycles, then Idle. PR to an Idle bank is a legal no-op.
REQ-021 PRA SHALL apply the PR rule to every bank in the same cycle. If any bank cannot legally precharge, the whole PRA is rejected and no bank changes.
REQ-022 REF SHALL be accepted only when all_idle=1; every bank then goes to Refreshing for T_RFC cycles, then Idle.
REQ-023 A command violating REQ-017..REQ-022 SHALL leave all states unchanged and assert cmd_illegal.
REQ-024 More than one bit set in commands SHALL be rejected as illegal.
REQ-025 BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX and SRF SHALL cause no state change and are not illegal.
REQ-026 A timed state SHALL never end early; with commands=0 every bank SHALL progress autonomously.
REQ-027 all_idle SHALL be combinational from the registered BankFSM values.

Reset
REQ-028 While reset=1, every BankFSM entry SHALL be 0x00, every counter 0, cmd_illegal 0, and all_idle 1.
REQ-029 Reset asserted mid-operation, including during Refreshing or Activating, SHALL abort immediately with no completion of the timed state.
REQ-030 Commands presented in the first edge after reset deassertion SHALL be processed normally.

Structure
REQ-031 A shared package SHALL hold the state-code enum, the command bit-index constants, and the command-vector width (19).
REQ-032 A per-bank sub-module bank_fsm SHALL hold the state register, the counter and transitions, and is instantiated via generate for every bg/ba pair.
REQ-033 The top level SHALL hold address decode, the PRA/REF global legality checks, and the cmd_illegal register.

Verification
REQ-034 ACT bg=1 ba=1 -> 0x01 two clocks later; 0x03 after T_RCD more cycles (17); other banks stay 0x00.
REQ-035 In Active: WR, then RD after 14 cycles, then WR after 8 cycles, then PR -> 0x12, 0x0b, 0x12, 0x0a; 0x00 seventeen cycles after entering 0x0a.
REQ-036 WRA -> 0x13 for 15 cycles, then 0x0a for 17, then 0x00; RDA -> 0x0c for 9 cycles, then 0x0a for 17, then 0x00.
REQ-037 REF with all banks idle -> all banks 0x0d for 34 cycles, then 0x00. REF with one bank Active -> cmd_illegal=1 for exactly one cycle and no state change.
REQ-038 Each of the following -> cmd_illegal=1 and unchanged state: RD to an Idle bank; ACT to an Active bank; commands=ACT|RD; PRA while one bank is Activating.
REQ-039 Reset asserted during Refreshing -> all banks 0x00 with no clock needed; ACT on the first edge after release -> 0x01.
